next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
//  Parametrised program-counter sequencer for the single-cycle/multicycle MIPS core. Owns the PC register.
//  Computes the next PC for sequential, branch, J, JAL and JR flow. Adds a circular return-address
//  stack (RAS) that checks JR-$ra targets against predictions. Sits between decode/ALU and instruction memory.
// PARAMETERS
//  PC_W       32            PC / register width in bits; must be >= 30
//  RAS_DEPTH  8             RAS entries; power of two, >= 2
//  RESET_VEC  32'h0000_0000 PC value loaded on reset (PC_W wide)
// PORTS
//  clk            in   1         rising-edge clock
//  rst            in   1         asynchronous, active-high reset
//  adv            in   1         advance: PC/RAS update this cycle (instruction retired)
//  stall          in   1         hold everything; overrides adv
//  flush_ras      in   1         clear RAS (count=0), PC unaffected
//  op             in   3         0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5 JR_RET (rs==$ra); 6,7 treated as SEQ
//  br_taken       in   1         branch condition from ALU, valid with op=BR
//  imm            in   16        branch offset (words, signed)
//  target         in   26        J/JAL word index
//  reg_addr       in   PC_W      rs value for JR / JR_RET
//  pc             out  PC_W      current PC (registered)
//  link_addr      out  PC_W      pc+4, combinational; writeback value for JAL
//  ras_top        out  PC_W      predicted return address (top entry; 0 when empty)
//  ras_count      out  clog2(RAS_DEPTH)+1  valid entries
//  ras_hit        out  1         1-cycle pulse: JR_RET target matched popped entry
//  ras_miss       out  1         1-cycle pulse: JR_RET target differed from popped entry
//  ras_underflow  out  1         1-cycle pulse: JR_RET with empty RAS
//  misalign       out  1         1-cycle pulse: JR/JR_RET target[1:0] != 0
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_VEC, RAS pointer=0, ras_count=0, all entries=0, all pulse outputs=0.
//  Update happens only on a rising clk with adv=1 and stall=0 (an "update cycle"). Otherwise pc and RAS hold.
//   All pulse outputs are 0 in non-update cycles.
//  All arithmetic is modulo 2^PC_W; p4 = pc+4.
//  Next PC per op:
//   SEQ: p4.
//   BR: br_taken ? p4 + (sext(imm)<<2) : p4.
//   J/JAL: {p4[PC_W-1:28], target, 2'b00}.
//   JR/JR_RET: {reg_addr[PC_W-1:2], 2'b00}. Low bits are forced to 0.
//    misalign=1 for that cycle if reg_addr[1:0] != 0.
//  Latency: new pc is visible on the output the cycle after the update edge. link_addr follows pc combinationally.
//  RAS push (JAL): write p4 at ptr, ptr=ptr+1 mod RAS_DEPTH, count=min(count+1, RAS_DEPTH).
//   When full, the oldest entry is silently overwritten (circular).
//  RAS pop (JR_RET, count>0): compare the popped entry with the masked JR target.
//   Equal -> ras_hit=1, else ras_miss=1. Then ptr=ptr-1 mod RAS_DEPTH, count=count-1.
//   pc always takes the JR target (the RAS only predicts; it never redirects).
//  JR_RET with count=0: ras_underflow=1, no pointer change, no hit/miss.
//  Plain JR does not touch the RAS.
//  ras_top = entry[ptr-1] when count>0, else 0.
//  flush_ras in an update cycle: takes priority over the op's RAS action, so there is no push/pop and no
//   hit/miss/underflow pulse. pc still updates normally. flush_ras without adv/stall gating still clears
//   (count=0, ptr=0). Entries need not be zeroed.
//  stall=1 with adv=1: full hold, no pulses. A flush_ras in that cycle still clears.
//  Reset asserted mid-operation overrides everything. No pending state survives.
//  Pulse outputs are registered and high for exactly the cycle following the update edge.
// TESTING
//  1 Reset: rst=1 -> pc=RESET_VEC, ras_count=0, all pulses 0. 3 SEQ updates -> pc=0x0,0x4,0x8,0xC.
//  2 Branch: pc=0x100, op=BR, imm=16'hFFFE, br_taken=1 -> pc=0xFC. With br_taken=0 -> pc=0x104.
//  3 Call/return: pc=0x40, JAL target=0x100 -> pc=0x400, ras_top=0x44, count=1.
//    Then JR_RET reg_addr=0x44 -> pc=0x44, ras_hit=1, count=0.
//    JR_RET reg_addr=0x48 instead -> ras_miss=1, pc=0x48.
//  4 Overflow/underflow: RAS_DEPTH+2 JALs -> count saturates at RAS_DEPTH, ras_top=last p4.
//    RAS_DEPTH+1 JR_RETs -> the last one gives ras_underflow=1, count stays 0.
//  5 Hold/flush/misalign: stall=1, adv=1, op=J -> pc unchanged, no pulses.
//    flush_ras=1 with count=3 -> count=0. JR reg_addr=0x203 -> pc=0x200, misalign=1.
//  6 Async reset mid-stream: assert rst between edges after 2 JALs -> pc=RESET_VEC, count=0 immediately (no clk edge).

Source files
------------

// File: rtl/next_pc_unit.sv
// next_pc_unit: program-counter sequencer for the MIPS core.
//   Owns the PC register, computes the next PC for sequential, branch, J, JAL
//   and JR flow, and keeps a circular return-address stack (RAS) that predicts
//   JR $ra targets and reports whether each prediction was right.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   adv            advance: PC/RAS update this cycle
//   stall          hold everything; overrides adv
//   flush_ras      clear the RAS (ungated); PC unaffected
//   op             0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5 JR_RET, 6/7 as SEQ
//   br_taken       branch condition, used with op=BR
//   imm            signed word offset for BR
//   target         26-bit word index for J/JAL
//   reg_addr       rs value for JR/JR_RET
//   pc             current PC (registered)
//   link_addr      pc+4 (combinational), JAL writeback value
//   ras_top        predicted return address, 0 when empty
//   ras_count      valid RAS entries
//   ras_hit/ras_miss/ras_underflow/misalign  registered one-cycle pulses
module next_pc_unit #(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adv,
  input  logic                         stall,
  input  logic                         flush_ras,
  input  logic [2:0]                   op,
  input  logic                         br_taken,
  input  logic [15:0]                  imm,
  input  logic [25:0]                  target,
  input  logic [PC_W-1:0]              reg_addr,
  output logic [PC_W-1:0]              pc,
  output logic [PC_W-1:0]              link_addr,
  output logic [PC_W-1:0]              ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_hit,
  output logic                         ras_miss,
  output logic                         ras_underflow,
  output logic                         misalign
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  localparam logic [PC_W-1:0] PcFour   = 4;
  localparam logic [PtrW-1:0] PtrOne   = 1;
  localparam logic [PtrW:0]   CountOne = 1;
  localparam logic [PtrW:0]   CountMax = RAS_DEPTH[PtrW:0];

  typedef enum logic [2:0] {
    OpSeq   = 3'd0,
    OpBr    = 3'd1,
    OpJ     = 3'd2,
    OpJal   = 3'd3,
    OpJr    = 3'd4,
    OpJrRet = 3'd5
  } op_e;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  logic            underflow_q, underflow_d;
  logic            misalign_q, misalign_d;

  logic [PC_W-1:0] p4;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jump_tgt;
  logic [PC_W-1:0] jr_tgt;
  logic [PC_W-1:0] npc;
  logic [PtrW-1:0] top_idx;
  logic            update;
  logic            ras_act;
  logic            push;
  logic            pop;
  op_e             op_dec;

  assign update    = adv & ~stall;
  // A flush in an update cycle suppresses the op's push/pop and its pulses.
  assign ras_act   = update & ~flush_ras;
  assign op_dec    = op_e'(op);

  assign p4        = pc_q + PcFour;
  assign br_off    = {{(PC_W-18){imm[15]}}, imm, 2'b00};
  assign jump_tgt  = {p4[PC_W-1:28], target, 2'b00};
  assign jr_tgt    = {reg_addr[PC_W-1:2], 2'b00};
  assign top_idx   = ptr_q - PtrOne;

  assign pc        = pc_q;
  assign link_addr = p4;
  assign ras_top   = (count_q != '0) ? ras_q[top_idx] : '0;
  assign ras_count = count_q;
  assign ras_hit       = hit_q;
  assign ras_miss      = miss_q;
  assign ras_underflow = underflow_q;
  assign misalign      = misalign_q;

  // Next PC and pulse decode.
  always_comb begin
    npc         = p4;
    misalign_d  = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    underflow_d = 1'b0;

    case (op_dec)
      OpBr: begin
        if (br_taken) begin
          npc = p4 + br_off;
        end
      end
      OpJ, OpJal: begin
        npc = jump_tgt;
      end
      OpJr, OpJrRet: begin
        npc        = jr_tgt;
        misalign_d = update & (reg_addr[1:0] != 2'b00);
      end
      default: begin
        npc = p4;
      end
    endcase

    if (ras_act && op_dec == OpJal) begin
      push = 1'b1;
    end

    // The RAS only predicts: pc always follows jr_tgt regardless of outcome.
    if (ras_act && op_dec == OpJrRet) begin
      if (count_q == '0) begin
        underflow_d = 1'b1;
      end else begin
        pop    = 1'b1;
        hit_d  = (ras_top == jr_tgt);
        miss_d = (ras_top != jr_tgt);
      end
    end

    pc_d = update ? npc : pc_q;
  end

  // RAS pointer/count. Flush is ungated by adv/stall.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (flush_ras) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push) begin
      ptr_d   = ptr_q + PtrOne;
      // When full the oldest entry is overwritten, so count saturates.
      count_d = (count_q == CountMax) ? count_q : count_q + CountOne;
    end else if (pop) begin
      ptr_d   = ptr_q - PtrOne;
      count_d = count_q - CountOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_VEC;
      ptr_q       <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      underflow_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      underflow_q <= underflow_d;
      misalign_q  <= misalign_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else if (push) begin
      ras_q[ptr_q] <= p4;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned RAS_DEPTH = 8;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        adv;
  logic        stall;
  logic        flush_ras;
  logic [2:0]  op;
  logic        br_taken;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] reg_addr;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic [31:0] ras_top;
  logic [3:0]  ras_count;
  logic        ras_hit;
  logic        ras_miss;
  logic        ras_underflow;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: PC plus the RAS as a bounded list (oldest at front).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        e_hit, e_miss, e_uf, e_mis;

  always #5 clk = ~clk;

  next_pc_unit #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_VEC (RESET_VEC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .adv           (adv),
    .stall         (stall),
    .flush_ras     (flush_ras),
    .op            (op),
    .br_taken      (br_taken),
    .imm           (imm),
    .target        (target),
    .reg_addr      (reg_addr),
    .pc            (pc),
    .link_addr     (link_addr),
    .ras_top       (ras_top),
    .ras_count     (ras_count),
    .ras_hit       (ras_hit),
    .ras_miss      (ras_miss),
    .ras_underflow (ras_underflow),
    .misalign      (misalign)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_top();
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
  endfunction

  task automatic check_all(input string ctx);
    check_val({ctx, ".pc"},        pc,        m_pc);
    check_val({ctx, ".link"},      link_addr, m_pc + 32'd4);
    check_val({ctx, ".count"},     {28'h0, ras_count}, m_ras.size());
    check_val({ctx, ".top"},       ras_top,   model_top());
    check_val({ctx, ".hit"},       {31'h0, ras_hit},       {31'h0, e_hit});
    check_val({ctx, ".miss"},      {31'h0, ras_miss},      {31'h0, e_miss});
    check_val({ctx, ".underflow"}, {31'h0, ras_underflow}, {31'h0, e_uf});
    check_val({ctx, ".misalign"},  {31'h0, misalign},      {31'h0, e_mis});
  endtask

  task automatic model_reset();
    m_pc = RESET_VEC;
    m_ras.delete();
    e_hit = 0; e_miss = 0; e_uf = 0; e_mis = 0;
  endtask

  // Apply one cycle of inputs, advance the model by the architectural rules,
  // then compare just after the rising edge.
  task automatic cycle(input string ctx, input bit a, input bit s, input bit f,
                       input logic [2:0] o, input bit bt, input logic [15:0] im,
                       input logic [25:0] tg, input logic [31:0] ra);
    logic [31:0] p4, nxt, jr, popped;
    adv = a; stall = s; flush_ras = f; op = o; br_taken = bt;
    imm = im; target = tg; reg_addr = ra;
    e_hit = 0; e_miss = 0; e_uf = 0; e_mis = 0;
    p4  = m_pc + 32'd4;
    jr  = ra & ~32'd3;
    nxt = p4;
    if (a && !s) begin
      case (o)
        3'd1: nxt = bt ? p4 + ({{16{im[15]}}, im} * 32'd4) : p4;
        3'd2, 3'd3: nxt = (p4 & 32'hF000_0000) | ({6'h0, tg} * 32'd4);
        3'd4, 3'd5: begin nxt = jr; e_mis = (ra[1:0] != 2'b00); end
        default: nxt = p4;
      endcase
      if (!f && o == 3'd3) begin
        m_ras.push_back(p4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end
      if (!f && o == 3'd5) begin
        if (m_ras.size() == 0) e_uf = 1;
        else begin
          popped = m_ras.pop_back();
          e_hit  = (popped == jr);
          e_miss = (popped != jr);
        end
      end
      m_pc = nxt;
    end
    if (f) m_ras.delete();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic set_pc(input logic [31:0] v);
    cycle("set_pc", 1, 0, 0, 3'd4, 0, 16'h0, 26'h0, v);
  endtask

  initial begin
    rst = 1; adv = 0; stall = 0; flush_ras = 0; op = 0; br_taken = 0;
    imm = 0; target = 0; reg_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 0;

    // Sequential flow
    for (int i = 0; i < 3; i++) cycle("seq", 1, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    check_val("seq.pc_c", pc, 32'hC);

    // Branch backward taken and not taken
    set_pc(32'h100);
    cycle("br_taken", 1, 0, 0, 3'd1, 1, 16'hFFFE, 26'h0, 32'h0);
    check_val("br_taken.abs", pc, 32'hFC);
    set_pc(32'h100);
    cycle("br_not", 1, 0, 0, 3'd1, 0, 16'hFFFE, 26'h0, 32'h0);
    check_val("br_not.abs", pc, 32'h104);

    // Call / return, hit then miss
    set_pc(32'h40);
    cycle("jal", 1, 0, 0, 3'd3, 0, 16'h0, 26'h100, 32'h0);
    check_val("jal.abs_pc", pc, 32'h400);
    check_val("jal.abs_top", ras_top, 32'h44);
    cycle("ret_hit", 1, 0, 0, 3'd5, 0, 16'h0, 26'h0, 32'h44);
    check_val("ret_hit.abs", {31'h0, ras_hit}, 32'h1);
    set_pc(32'h40);
    cycle("jal2", 1, 0, 0, 3'd3, 0, 16'h0, 26'h100, 32'h0);
    cycle("ret_miss", 1, 0, 0, 3'd5, 0, 16'h0, 26'h0, 32'h48);
    check_val("ret_miss.abs", {31'h0, ras_miss}, 32'h1);

    // Overflow then drain past empty
    for (int i = 0; i < RAS_DEPTH + 2; i++)
      cycle("ovf_jal", 1, 0, 0, 3'd3, 0, 16'h0, 26'(i * 16 + 3), 32'h0);
    check_val("ovf.count", {28'h0, ras_count}, RAS_DEPTH);
    for (int i = 0; i < RAS_DEPTH + 1; i++)
      cycle("drain", 1, 0, 0, 3'd5, 0, 16'h0, 26'h0, model_top());
    check_val("drain.underflow", {31'h0, ras_underflow}, 32'h1);

    // Hold, flush, misalign
    cycle("stall_j", 1, 1, 0, 3'd2, 0, 16'h0, 26'h3FF, 32'h0);
    for (int i = 0; i < 3; i++) cycle("fl_jal", 1, 0, 0, 3'd3, 0, 16'h0, 26'(i + 1), 32'h0);
    cycle("flush_idle", 0, 0, 1, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    for (int i = 0; i < 2; i++) cycle("fl_jal2", 1, 0, 0, 3'd3, 0, 16'h0, 26'(i + 9), 32'h0);
    cycle("flush_stall", 1, 1, 1, 3'd5, 0, 16'h0, 26'h0, 32'h0);
    cycle("flush_upd", 1, 0, 1, 3'd3, 0, 16'h0, 26'h55, 32'h0);
    cycle("jr_mis", 1, 0, 0, 3'd4, 0, 16'h0, 26'h0, 32'h203);
    check_val("jr_mis.abs", pc, 32'h200);

    // Async reset between edges
    cycle("pre_rst1", 1, 0, 0, 3'd3, 0, 16'h0, 26'h77, 32'h0);
    cycle("pre_rst2", 1, 0, 0, 3'd3, 0, 16'h0, 26'h78, 32'h0);
    #1 rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 0;

    // Randomised traffic, returns biased toward the predicted address
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra;
      logic [2:0]  o;
      int          sel;
      o   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) o = 3'd5;
      sel = $urandom_range(0, 3);
      ra  = (sel == 0) ? $urandom() :
            (sel == 1) ? (model_top() | 32'($urandom_range(0, 3))) : model_top();
      cycle("rand", $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 1,
            $urandom_range(0, 19) == 0, o, 1'($urandom()), 16'($urandom()),
            26'($urandom()), ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
